// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access kinds and response status codes.
// Bit positions let decoders test write/non-posted without full compares.
package rggen_rtl_pkg;
  localparam int RGGEN_ACCESS_DATA_BIT       = 0;
  localparam int RGGEN_ACCESS_NON_POSTED_BIT = 1;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b10,
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

// File: rtl/rggen_access_timer.sv
// Access watchdog: i_clear zeroes, i_count advances (saturating), o_expire
// flags the last allowed cycle. TIMEOUT_CYCLES=0 ties o_expire low.
module rggen_access_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);
  localparam int W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST  =
    (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_count && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign o_expire = (TIMEOUT_CYCLES != 0) && (count == LAST);
endmodule

// File: rtl/rggen_register_access_initiator.sv
// Host-to-register-bus initiator: one command in flight, IDLE/ACCESS/RESPONSE.
// Ports: host cmd (valid/ready), response (valid/ready), register bus out/in.
module rggen_register_access_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH   = 8,
  parameter int                   BUS_WIDTH       = 32,
  parameter int                   ALIGN_LSB       = 2,
  parameter int                   TIMEOUT_CYCLES  = 0,
  parameter logic [BUS_WIDTH-1:0] ERROR_READ_DATA = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_host_valid,
  output logic                     o_host_ready,
  input  rggen_access              i_host_access,
  input  logic [ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [BUS_WIDTH-1:0]     i_host_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_host_strobe,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output rggen_status              o_resp_status,
  output logic [BUS_WIDTH-1:0]     o_resp_read_data,
  output logic                     o_reg_valid,
  output rggen_access              o_reg_access,
  output logic [ADDRESS_WIDTH-1:0] o_reg_address,
  output logic [BUS_WIDTH-1:0]     o_reg_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_reg_strobe,
  input  logic                     i_reg_active,
  input  logic                     i_reg_ready,
  input  rggen_status              i_reg_status,
  input  logic [BUS_WIDTH-1:0]     i_reg_read_data
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
    ~ADDRESS_WIDTH'((64'd1 << ALIGN_LSB) - 64'd1);

  state_e               state;
  state_e               state_next;
  logic                 accept;
  logic                 complete;
  logic                 expire;
  logic                 host_write;
  rggen_status          status_next;
  logic [BUS_WIDTH-1:0] data_next;

  assign accept     = (state == IDLE) && i_host_valid;
  assign host_write = i_host_access[RGGEN_ACCESS_DATA_BIT];

  rggen_access_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (accept),
    .i_count  (state == ACCESS),
    .o_expire (expire)
  );

  // Completion priority: decode miss, then register ready, then timeout.
  always_comb begin
    state_next  = state;
    complete    = 1'b0;
    status_next = RGGEN_OKAY;
    data_next   = '0;
    unique case (state)
      IDLE: begin
        if (i_host_valid) state_next = ACCESS;
      end
      ACCESS: begin
        priority case (1'b1)
          !i_reg_active: begin
            complete    = 1'b1;
            status_next = RGGEN_DECODE_ERROR;
            data_next   = ERROR_READ_DATA;
          end
          i_reg_ready: begin
            complete    = 1'b1;
            status_next = i_reg_status;
            if (!o_reg_access[RGGEN_ACCESS_DATA_BIT]) begin
              data_next = i_reg_read_data;
            end
          end
          expire: begin
            complete    = 1'b1;
            status_next = RGGEN_SLAVE_ERROR;
            data_next   = ERROR_READ_DATA;
          end
          default: ;
        endcase
        if (complete) state_next = RESPONSE;
      end
      RESPONSE: begin
        if (i_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      o_reg_access     <= RGGEN_READ;
      o_reg_address    <= '0;
      o_reg_write_data <= '0;
      o_reg_strobe     <= '0;
      o_resp_status    <= RGGEN_OKAY;
      o_resp_read_data <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        o_reg_access     <= i_host_access;
        o_reg_address    <= i_host_address & ADDR_MASK;
        o_reg_write_data <= i_host_write_data;
        o_reg_strobe     <= host_write ? i_host_strobe : '0;
      end
      if (complete) begin
        o_resp_status    <= status_next;
        o_resp_read_data <= data_next;
      end
    end
  end

  assign o_host_ready = (state == IDLE);
  assign o_reg_valid  = (state == ACCESS);
  assign o_resp_valid = (state == RESPONSE);
endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// Directed bench for rggen_register_access_initiator: vector table plus
// hand sequences for backpressure and mid-access reset.
module tb_rggen_register_access_initiator;
  import rggen_rtl_pkg::*;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_host_valid = 1'b0;
  logic        o_host_ready;
  rggen_access i_host_access = RGGEN_READ;
  logic [7:0]  i_host_address = '0;
  logic [31:0] i_host_write_data = '0;
  logic [3:0]  i_host_strobe = '0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  rggen_status o_resp_status;
  logic [31:0] o_resp_read_data;
  logic        o_reg_valid;
  rggen_access o_reg_access;
  logic [7:0]  o_reg_address;
  logic [31:0] o_reg_write_data;
  logic [3:0]  o_reg_strobe;
  logic        i_reg_active = 1'b0;
  logic        i_reg_ready = 1'b0;
  rggen_status i_reg_status = RGGEN_OKAY;
  logic [31:0] i_reg_read_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  rggen_register_access_initiator #(
    .ADDRESS_WIDTH   (8),
    .BUS_WIDTH       (32),
    .ALIGN_LSB       (2),
    .TIMEOUT_CYCLES  (4),
    .ERROR_READ_DATA (ERR_DATA)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_host_valid      (i_host_valid),
    .o_host_ready      (o_host_ready),
    .i_host_access     (i_host_access),
    .i_host_address    (i_host_address),
    .i_host_write_data (i_host_write_data),
    .i_host_strobe     (i_host_strobe),
    .o_resp_valid      (o_resp_valid),
    .i_resp_ready      (i_resp_ready),
    .o_resp_status     (o_resp_status),
    .o_resp_read_data  (o_resp_read_data),
    .o_reg_valid       (o_reg_valid),
    .o_reg_access      (o_reg_access),
    .o_reg_address     (o_reg_address),
    .o_reg_write_data  (o_reg_write_data),
    .o_reg_strobe      (o_reg_strobe),
    .i_reg_active      (i_reg_active),
    .i_reg_ready       (i_reg_ready),
    .i_reg_status      (i_reg_status),
    .i_reg_read_data   (i_reg_read_data)
  );

  typedef struct {
    rggen_access acc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        active;
    int          rdy;
    rggen_status rstat;
    logic [31:0] rdata;
    logic [7:0]  e_addr;
    logic [3:0]  e_strb;
    rggen_status e_stat;
    logic [31:0] e_data;
    int          e_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge i_clk);
    check({t, " host_ready"}, 32'(o_host_ready), 32'd1);
    i_host_valid      = 1'b1;
    i_host_access     = v.acc;
    i_host_address    = v.addr;
    i_host_write_data = v.wdata;
    i_host_strobe     = v.strb;
    @(negedge i_clk);
    i_host_valid = 1'b0;
    n = 0;
    while (o_reg_valid && n < 20) begin
      n++;
      check({t, " reg_address"}, 32'(o_reg_address), 32'(v.e_addr));
      if (n == 1) begin
        check({t, " reg_strobe"}, 32'(o_reg_strobe), 32'(v.e_strb));
        check({t, " reg_access"}, 32'(o_reg_access), 32'(v.acc));
        check({t, " reg_wdata"}, o_reg_write_data, v.wdata);
      end
      i_reg_active    = v.active;
      i_reg_ready     = (n == v.rdy);
      i_reg_status    = v.rstat;
      i_reg_read_data = v.rdata;
      @(negedge i_clk);
    end
    i_reg_active    = 1'b0;
    i_reg_ready     = 1'b0;
    i_reg_status    = RGGEN_OKAY;
    i_reg_read_data = '0;
    check({t, " valid_cycles"}, 32'(n), 32'(v.e_cyc));
    check({t, " resp_valid"}, 32'(o_resp_valid), 32'd1);
    check({t, " resp_status"}, 32'(o_resp_status), 32'(v.e_stat));
    check({t, " resp_data"}, o_resp_read_data, v.e_data);
    i_resp_ready = 1'b1;
    @(negedge i_clk);
    i_resp_ready = 1'b0;
    check({t, " resp_done"}, 32'(o_resp_valid), 32'd0);
    check({t, " ready_back"}, 32'(o_host_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{RGGEN_READ, 8'h14, 32'h0, 4'hF, 1'b1, 2, RGGEN_OKAY,
                32'hCAFE_F00D, 8'h14, 4'h0, RGGEN_OKAY, 32'hCAFE_F00D, 2};
    vecs[1] = '{RGGEN_WRITE, 8'h1B, 32'h1357_9BDF, 4'b0101, 1'b1, 1,
                RGGEN_OKAY, 32'h1234_5678, 8'h18, 4'b0101, RGGEN_OKAY,
                32'h0, 1};
    vecs[2] = '{RGGEN_WRITE, 8'hFC, 32'hFFFF_0000, 4'hF, 1'b0, 1,
                RGGEN_OKAY, 32'h0, 8'hFC, 4'hF, RGGEN_DECODE_ERROR,
                ERR_DATA, 1};
    vecs[3] = '{RGGEN_READ, 8'h20, 32'h0, 4'hF, 1'b1, 0, RGGEN_OKAY,
                32'h5555_5555, 8'h20, 4'h0, RGGEN_SLAVE_ERROR, ERR_DATA, 4};
    vecs[4] = '{RGGEN_READ, 8'h24, 32'h0, 4'h0, 1'b1, 4, RGGEN_OKAY,
                32'hA5A5_0001, 8'h24, 4'h0, RGGEN_OKAY, 32'hA5A5_0001, 4};
    vecs[5] = '{RGGEN_POSTED_WRITE, 8'h33, 32'h0000_BEEF, 4'hC, 1'b1, 3,
                RGGEN_OKAY, 32'h7777_7777, 8'h30, 4'hC, RGGEN_OKAY, 32'h0, 3};
    vecs[6] = '{RGGEN_POSTED_WRITE, 8'h40, 32'h0, 4'h3, 1'b0, 0,
                RGGEN_OKAY, 32'h0, 8'h40, 4'h3, RGGEN_DECODE_ERROR,
                ERR_DATA, 1};

    repeat (3) @(negedge i_clk);
    check("rst host_ready", 32'(o_host_ready), 32'd1);
    check("rst reg_valid", 32'(o_reg_valid), 32'd0);
    check("rst resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst resp_status", 32'(o_resp_status), 32'(RGGEN_OKAY));
    check("rst reg_address", 32'(o_reg_address), 32'd0);
    check("rst reg_strobe", 32'(o_reg_strobe), 32'd0);
    check("rst resp_data", o_resp_read_data, 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Backpressure: response held 5 cycles while a second command waits.
    @(negedge i_clk);
    i_host_valid   = 1'b1;
    i_host_access  = RGGEN_READ;
    i_host_address = 8'h08;
    @(negedge i_clk);
    i_host_address = 8'h0C;
    check("bp reg_valid", 32'(o_reg_valid), 32'd1);
    i_reg_active    = 1'b1;
    i_reg_ready     = 1'b1;
    i_reg_read_data = 32'h0BAD_CAFE;
    @(negedge i_clk);
    i_reg_read_data = 32'h1111_2222;
    i_reg_active    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp resp_valid", 32'(o_resp_valid), 32'd1);
      check("bp resp_data", o_resp_read_data, 32'h0BAD_CAFE);
      check("bp resp_status", 32'(o_resp_status), 32'(RGGEN_OKAY));
      check("bp host_ready", 32'(o_host_ready), 32'd0);
      check("bp reg_valid", 32'(o_reg_valid), 32'd0);
      @(negedge i_clk);
    end
    i_resp_ready = 1'b1;
    @(negedge i_clk);
    i_resp_ready = 1'b0;
    i_reg_ready  = 1'b0;
    check("bp idle host_ready", 32'(o_host_ready), 32'd1);
    check("bp not_yet", 32'(o_reg_valid), 32'd0);
    @(negedge i_clk);
    i_host_valid = 1'b0;
    check("bp 2nd reg_valid", 32'(o_reg_valid), 32'd1);
    check("bp 2nd address", 32'(o_reg_address), 32'h0C);
    i_reg_active = 1'b1;
    i_reg_ready  = 1'b1;
    @(negedge i_clk);
    i_reg_active = 1'b0;
    i_reg_ready  = 1'b0;
    check("bp 2nd resp_data", o_resp_read_data, 32'h1111_2222);
    i_resp_ready = 1'b1;
    @(negedge i_clk);
    i_resp_ready = 1'b0;

    // Reset while in ACCESS drops the command without a response.
    i_host_valid   = 1'b1;
    i_host_access  = RGGEN_READ;
    i_host_address = 8'h50;
    @(negedge i_clk);
    i_host_valid = 1'b0;
    check("rs reg_valid", 32'(o_reg_valid), 32'd1);
    i_reg_active = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("rs mid reg_valid", 32'(o_reg_valid), 32'd0);
    check("rs mid host_ready", 32'(o_host_ready), 32'd1);
    check("rs mid resp_valid", 32'(o_resp_valid), 32'd0);
    @(negedge i_clk);
    i_rst_n     = 1'b1;
    i_reg_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("rs post resp_valid", 32'(o_resp_valid), 32'd0);
      check("rs post reg_valid", 32'(o_reg_valid), 32'd0);
    end
    i_reg_active = 1'b0;
    i_reg_ready  = 1'b0;
    run_vec(7, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
